// File: rtl/sct_req_sequencer_if.sv
// Request/grant bundle between the request sequencer and its environment.
interface sct_req_sequencer_if #(
  parameter int unsigned NCH = 5
) ();
  logic           enable;
  logic [NCH-1:0] evt;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] req;
  logic           busy;
  logic [NCH-1:0] done;
  logic           tmo;
  logic [NCH-1:0] pending;

  modport master (
    input  enable, evt, grant,
    output req, busy, done, tmo, pending
  );

  modport slave (
    output enable, evt, grant,
    input  req, busy, done, tmo, pending
  );
endinterface

// File: rtl/sct_req_sequencer.sv
// Requester-side sequencer: latches per-channel events and issues one request at a time.
// Optional SCT_REQ_ROUND_ROBIN_EN selects round-robin instead of fixed lowest-index priority.
module sct_req_sequencer #(
  parameter int unsigned NCH      = 5,
  parameter int unsigned TMO_W    = 6,
  parameter int unsigned TMO_MAX  = 40,
  parameter int unsigned HOLD_CYC = 2
) (
  input logic               clock,
  input logic               reset,
  sct_req_sequencer_if.master bus
);

  localparam int unsigned SelW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [TMO_W-1:0] TmoLast  = TMO_W'(TMO_MAX - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StRel} state_e;

  state_e           state_q, state_d;
  logic [SelW-1:0]  sel_q, sel_d;
  logic [SelW-1:0]  pick, cand;
  logic             pick_valid;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             abort_q, abort_d;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   req_q, req_d;
  logic [NCH-1:0]   done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [NCH-1:0]   clr;

`ifdef SCT_REQ_ROUND_ROBIN_EN
  logic [SelW-1:0] last_q;

  // Search starts one above the last serviced channel and wraps.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = SelW'((int unsigned'(last_q) + k) % NCH);
      if (!pick_valid && pending_q[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= SelW'(NCH - 1);
    end else if (state_q == StRel) begin
      last_q <= sel_q;
    end
  end
`else
  // Descending scan so the lowest set index is the final assignment.
  always_comb begin
    pick       = '0;
    cand       = '0;
    pick_valid = |pending_q;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = SelW'(i);
      if (pending_q[cand]) begin
        pick = cand;
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tmo_cnt_d  = tmo_cnt_q;
    hold_cnt_d = hold_cnt_q;
    abort_d    = abort_q;
    clr        = '0;
    case (state_q)
      StIdle: begin
        if (bus.enable && pick_valid) begin
          state_d   = StReq;
          sel_d     = pick;
          tmo_cnt_d = '0;
          abort_d   = 1'b0;
        end
      end
      StReq: begin
        // A grant arriving on the final wait cycle still wins over the abort.
        if (bus.grant[sel_q]) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d = StRel;
          abort_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StRel;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRel: begin
        state_d = StIdle;
        clr     = NCH'(1) << sel_q;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    req_d  = ((state_d == StReq) || (state_d == StHold)) ? (NCH'(1) << sel_d) : '0;
    done_d = ((state_d == StRel) && !abort_d) ? (NCH'(1) << sel_d) : '0;
    tmo_d  = (state_d == StRel) && abort_d;

    // A new event on the channel being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | bus.evt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      tmo_cnt_q  <= '0;
      hold_cnt_q <= '0;
      abort_q    <= 1'b0;
      pending_q  <= '0;
      req_q      <= '0;
      done_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tmo_cnt_q  <= tmo_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      abort_q    <= abort_d;
      pending_q  <= pending_d;
      req_q      <= req_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.req     = req_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.tmo     = tmo_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_sct_req_sequencer.sv
// Self-checking bench for sct_req_sequencer: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_sct_req_sequencer;

  localparam int NCH  = 5;
  localparam int TMO  = 40;
  localparam int HOLD = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sct_req_sequencer_if #(.NCH(NCH)) bus ();

  sct_req_sequencer #(
    .NCH      (NCH),
    .TMO_W    (6),
    .TMO_MAX  (TMO),
    .HOLD_CYC (HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: current transaction as "channel + cycles spent waiting/holding".
  logic [4:0] m_pend  = '0;
  int         m_cur   = -1;
  int         m_wait  = 0;
  int         m_hold  = -1;
  bit         m_rel   = 1'b0;
  bit         m_abort = 1'b0;
  int         m_last  = NCH - 1;

  function automatic int model_pick();
    int idx;
    for (int k = 1; k <= NCH; k++) begin
`ifdef SCT_REQ_ROUND_ROBIN_EN
      idx = (m_last + k) % NCH;
`else
      idx = k - 1;
`endif
      if (m_pend[idx[2:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [4:0] onehot(input int ch);
    logic [4:0] v;
    v = '0;
    v[ch[2:0]] = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] exp_req();
    return (m_cur >= 0 && !m_rel) ? onehot(m_cur) : 5'b0;
  endfunction

  function automatic logic [4:0] exp_done();
    return (m_cur >= 0 && m_rel && !m_abort) ? onehot(m_cur) : 5'b0;
  endfunction

  task automatic model_step(input logic r, input logic en, input logic [4:0] ev,
                            input logic [4:0] gr);
    logic [4:0] clr;
    int p;
    clr = '0;
    if (r) begin
      m_pend = '0; m_cur = -1; m_wait = 0; m_hold = -1;
      m_rel = 1'b0; m_abort = 1'b0; m_last = NCH - 1;
      return;
    end
    if (m_cur < 0) begin
      p = model_pick();
      if (en && p >= 0) begin
        m_cur = p; m_wait = 0; m_hold = -1; m_rel = 1'b0; m_abort = 1'b0;
      end
    end else if (m_rel) begin
      clr = onehot(m_cur);
      m_last = m_cur;
      m_cur = -1;
      m_rel = 1'b0;
    end else if (m_hold >= 0) begin
      m_hold++;
      if (m_hold == HOLD) m_rel = 1'b1;
    end else if (gr[m_cur[2:0]]) begin
      m_hold = 0;
    end else begin
      m_wait++;
      if (m_wait == TMO) begin
        m_rel = 1'b1;
        m_abort = 1'b1;
      end
    end
    m_pend = (m_pend & ~clr) | ev;
  endtask

  // Drive one clock of inputs, advance the model on the same edge, then settle.
  task automatic cycle(input logic r, input logic en, input logic [4:0] ev, input logic [4:0] gr);
    reset      = r;
    bus.enable = en;
    bus.evt    = ev;
    bus.grant  = gr;
    @(posedge clock);
    model_step(r, en, ev, gr);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 5'b0, bus.req);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 5'b11111, 5'b0);
    cycle(1'b1, 1'b1, 5'b0, 5'b0);
    n_cmp++;
    if (bus.req !== 5'b0) begin
      n_err++; $display("FAIL reset_req: got %b expected %b", bus.req, 5'b0);
    end
    n_cmp++;
    if (bus.pending !== 5'b0) begin
      n_err++; $display("FAIL reset_pending: got %b expected %b", bus.pending, 5'b0);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.tmo !== 1'b0 || bus.done !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got busy=%b tmo=%b done=%b expected 0/0/00000",
               bus.busy, bus.tmo, bus.done);
    end
  endtask

  task automatic test_single();
    int req_cycles = 0;
    int done_cnt   = 0;
    bit busy_rel   = 1'b0;
    cycle(1'b0, 1'b1, 5'b00100, 5'b0);
    n_cmp++;
    if (bus.pending !== 5'b00100 || bus.req !== 5'b0) begin
      n_err++;
      $display("FAIL single_pending: got pending=%b req=%b expected 00100/00000",
               bus.pending, bus.req);
    end
    cycle(1'b0, 1'b1, 5'b0, 5'b0);
    n_cmp++;
    if (bus.req !== 5'b00100) begin
      n_err++; $display("FAIL single_req_latency: got %b expected %b", bus.req, 5'b00100);
    end
    for (int i = 0; i < 8; i++) begin
      if (bus.req === 5'b00100) req_cycles++;
      cycle(1'b0, 1'b1, 5'b0, (i == 0) ? 5'b00100 : 5'b0);
      if (bus.done === 5'b00100) begin
        done_cnt++;
        busy_rel = bus.busy;
      end
    end
    n_cmp++;
    if (req_cycles != 1 + HOLD) begin
      n_err++; $display("FAIL single_req_cycles: got %0d expected %0d", req_cycles, 1 + HOLD);
    end
    n_cmp++;
    if (done_cnt != 1 || busy_rel !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: got count=%0d busy_in_rel=%b expected 1/1", done_cnt, busy_rel);
    end
    n_cmp++;
    if (bus.pending !== 5'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_after: got pending=%b busy=%b expected 00000/0",
               bus.pending, bus.busy);
    end
  endtask

  task automatic test_priority();
    logic [4:0] seen[$];
    int         when[$];
    cycle(1'b1, 1'b1, 5'b0, 5'b0);
    cycle(1'b0, 1'b1, 5'b10010, 5'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 5'b0, bus.req);
      if (bus.done !== 5'b0) begin
        seen.push_back(bus.done);
        when.push_back(i);
      end
    end
    n_cmp++;
    if (seen.size() != 2) begin
      n_err++; $display("FAIL prio_count: got %0d expected 2", seen.size());
    end else begin
      n_cmp++;
      if (seen[0] !== 5'b00010 || seen[1] !== 5'b10000) begin
        n_err++;
        $display("FAIL prio_order: got %b,%b expected 00010,10000", seen[0], seen[1]);
      end
      n_cmp++;
      if (when[1] - when[0] != 3 + HOLD) begin
        n_err++;
        $display("FAIL prio_gap: got %0d expected %0d", when[1] - when[0], 3 + HOLD);
      end
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int tmo_cnt    = 0;
    int done_cnt   = 0;
    cycle(1'b0, 1'b1, 5'b00001, 5'b0);
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'b1, 5'b0, 5'b0);
      if (bus.req === 5'b00001) req_cycles++;
      if (bus.tmo === 1'b1) tmo_cnt++;
      if (bus.done !== 5'b0) done_cnt++;
    end
    n_cmp++;
    if (req_cycles != TMO) begin
      n_err++; $display("FAIL tmo_req_cycles: got %0d expected %0d", req_cycles, TMO);
    end
    n_cmp++;
    if (tmo_cnt != 1 || done_cnt != 0) begin
      n_err++;
      $display("FAIL tmo_pulses: got tmo=%0d done=%0d expected 1/0", tmo_cnt, done_cnt);
    end
    n_cmp++;
    if (bus.pending !== 5'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_after: got pending=%b busy=%b expected 00000/0", bus.pending, bus.busy);
    end
  endtask

  task automatic test_rearm();
    bit armed = 1'b0;
    logic [4:0] ev;
    cycle(1'b0, 1'b1, 5'b01000, 5'b0);
    for (int i = 0; i < 30 && !armed; i++) begin
      ev = 5'b0;
      if (bus.done === 5'b01000) begin
        ev = 5'b01000;
        armed = 1'b1;
      end
      cycle(1'b0, 1'b1, ev, bus.req);
    end
    n_cmp++;
    if (!armed) begin
      n_err++; $display("FAIL rearm_rel_seen: got none expected done=01000 within 30 cycles");
    end else begin
      n_cmp++;
      if (bus.pending[3] !== 1'b1 || bus.req !== 5'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL rearm_idle: got pending=%b req=%b busy=%b expected x1xxx/00000/0",
                 bus.pending, bus.req, bus.busy);
      end
      cycle(1'b0, 1'b1, 5'b0, 5'b0);
      n_cmp++;
      if (bus.req !== 5'b01000) begin
        n_err++; $display("FAIL rearm_req: got %b expected %b", bus.req, 5'b01000);
      end
    end
    drain(10);
  endtask

  task automatic test_reset_mid_hold();
    cycle(1'b0, 1'b1, 5'b00010, 5'b0);
    cycle(1'b0, 1'b1, 5'b0, 5'b0);
    cycle(1'b0, 1'b1, 5'b0, 5'b00010);
    cycle(1'b0, 1'b1, 5'b0, 5'b0);
    n_cmp++;
    if (bus.req !== 5'b00010) begin
      n_err++; $display("FAIL rsthold_pre: got %b expected %b", bus.req, 5'b00010);
    end
    cycle(1'b1, 1'b1, 5'b0, 5'b0);
    n_cmp++;
    if (bus.req !== 5'b0 || bus.pending !== 5'b0 || bus.busy !== 1'b0 ||
        bus.done !== 5'b0 || bus.tmo !== 1'b0) begin
      n_err++;
      $display("FAIL rsthold_post: got req=%b pend=%b busy=%b done=%b tmo=%b expected all 0",
               bus.req, bus.pending, bus.busy, bus.done, bus.tmo);
    end
    cycle(1'b0, 1'b1, 5'b0, 5'b0);
    n_cmp++;
    if (bus.done !== 5'b0 || bus.tmo !== 1'b0) begin
      n_err++;
      $display("FAIL rsthold_nopulse: got done=%b tmo=%b expected 00000/0", bus.done, bus.tmo);
    end
  endtask

  task automatic test_enable_gating();
    int bad = 0;
    cycle(1'b0, 1'b0, 5'b01000, 5'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 5'b0, 5'b0);
      if (bus.req !== 5'b0 || bus.busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0 || bus.pending !== 5'b01000) begin
      n_err++;
      $display("FAIL gate_hold: got %0d active cycles pending=%b expected 0/01000",
               bad, bus.pending);
    end
    cycle(1'b0, 1'b1, 5'b0, 5'b0);
    n_cmp++;
    if (bus.req !== 5'b01000) begin
      n_err++; $display("FAIL gate_release: got %b expected %b", bus.req, 5'b01000);
    end
    drain(10);
  endtask

  task automatic test_random();
    logic       r, en;
    logic [4:0] ev, gr, rnd;
    bit         stingy;
    int         roll;
    for (int c = 0; c < 3000; c++) begin
      stingy = ((c / 150) % 3) == 2;
      r  = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 9) != 0);
      ev = '0;
      for (int b = 0; b < NCH; b++) if ($urandom_range(0, 11) == 0) ev[b] = 1'b1;
      rnd  = 5'($urandom);
      roll = $urandom_range(0, 99);
      if (stingy)        gr = rnd & ~bus.req;
      else if (roll < 30) gr = bus.req | rnd;
      else if (roll < 60) gr = rnd & ~bus.req;
      else               gr = '0;
      cycle(r, en, ev, gr);
      n_cmp++;
      if (bus.req !== exp_req()) begin
        n_err++; $display("FAIL rand_req c=%0d: got %b expected %b", c, bus.req, exp_req());
      end
      n_cmp++;
      if (bus.pending !== m_pend) begin
        n_err++; $display("FAIL rand_pending c=%0d: got %b expected %b", c, bus.pending, m_pend);
      end
      n_cmp++;
      if (bus.busy !== (m_cur >= 0)) begin
        n_err++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, bus.busy, m_cur >= 0);
      end
      n_cmp++;
      if (bus.done !== exp_done()) begin
        n_err++; $display("FAIL rand_done c=%0d: got %b expected %b", c, bus.done, exp_done());
      end
      n_cmp++;
      if (bus.tmo !== (m_cur >= 0 && m_rel && m_abort)) begin
        n_err++;
        $display("FAIL rand_tmo c=%0d: got %b expected %b", c, bus.tmo,
                 m_cur >= 0 && m_rel && m_abort);
      end
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.evt    = '0;
    bus.grant  = '0;
    test_reset();
    test_single();
    test_priority();
    test_timeout();
    test_rearm();
    test_reset_mid_hold();
    test_enable_gating();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
